// File: rtl/mmss_pkg.sv
// Shared types and segment constants for the minutes:seconds stopwatch.
package mmss_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  // Active-low segment codes, bit0 = a ... bit6 = g
  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_BLANK = 7'h7F;

  localparam bcd_t BCD_UNITS_MAX = 4'd9;
  localparam bcd_t BCD_TENS_MAX  = 4'd5;

  // Next value of a BCD digit given its increment enable and wrap point.
  function automatic bcd_t bcd_next(input bcd_t d, input logic inc, input bcd_t max);
    bcd_t r;
    r = d;
    if (inc) begin
      if (d == max) r = 4'd0;
      else          r = d + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low 7-segment pattern; out-of-range values show blank.
module seg7_decoder
  import mmss_pkg::*;
(
  input  bcd_t i_bcd,
  output seg_t o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/mmss_counter.sv
// Minutes:seconds BCD stopwatch with start/stop toggle, clear and four 7-seg digits.
//   state   | meaning
//   STOPPED | ticks ignored (reset state)
//   RUNNING | each tick advances the count
module mmss_counter
  import mmss_pkg::*;
#(
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       key_start,
  input  logic       clear,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic       running,
  output logic       wrap
);

  state_t r_state;
  state_t w_state_next;
  logic   r_key_q;
  logic   r_wrap;
  bcd_t   r_s0, r_s1, r_m0, r_m1;
  bcd_t   w_s0_next, w_s1_next, w_m0_next, w_m1_next;
  logic   w_start_edge;
  logic   w_cnt;
  logic   w_c0, w_c1, w_c2, w_c3;
  seg_t   w_hex3_raw;

  assign w_start_edge = key_start & ~r_key_q;

  // Tick qualified by the pre-edge state, so a start+tick is not counted
  // while a stop+tick is.
  assign w_cnt = tick & (r_state == RUNNING) & ~clear;
  assign w_c0  = w_cnt & (r_s0 == BCD_UNITS_MAX);
  assign w_c1  = w_c0  & (r_s1 == BCD_TENS_MAX);
  assign w_c2  = w_c1  & (r_m0 == BCD_UNITS_MAX);
  assign w_c3  = w_c2  & (r_m1 == BCD_TENS_MAX);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) r_state <= STOPPED;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = STOPPED;
    end else if (w_start_edge) begin
      w_state_next = (r_state == RUNNING) ? STOPPED : RUNNING;
    end
  end

  always_comb begin
    w_s0_next = bcd_next(r_s0, w_cnt, BCD_UNITS_MAX);
    w_s1_next = bcd_next(r_s1, w_c0,  BCD_TENS_MAX);
    w_m0_next = bcd_next(r_m0, w_c1,  BCD_UNITS_MAX);
    w_m1_next = bcd_next(r_m1, w_c2,  BCD_TENS_MAX);
    if (clear) begin
      w_s0_next = 4'd0;
      w_s1_next = 4'd0;
      w_m0_next = 4'd0;
      w_m1_next = 4'd0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_key_q <= 1'b0;
      r_wrap  <= 1'b0;
      r_s0    <= 4'd0;
      r_s1    <= 4'd0;
      r_m0    <= 4'd0;
      r_m1    <= 4'd0;
    end else begin
      r_key_q <= key_start;
      r_wrap  <= w_c3;
      r_s0    <= w_s0_next;
      r_s1    <= w_s1_next;
      r_m0    <= w_m0_next;
      r_m1    <= w_m1_next;
    end
  end

  assign running = (r_state == RUNNING);
  assign wrap    = r_wrap;

  seg7_decoder u_dec0 (.i_bcd(r_s0), .o_seg(HEX0));
  seg7_decoder u_dec1 (.i_bcd(r_s1), .o_seg(HEX1));
  seg7_decoder u_dec2 (.i_bcd(r_m0), .o_seg(HEX2));
  seg7_decoder u_dec3 (.i_bcd(r_m1), .o_seg(w_hex3_raw));

  assign HEX3 = (BLANK_LEADING && (r_m1 == 4'd0)) ? SEG_BLANK : w_hex3_raw;

endmodule

// File: tb/tb_mmss_counter.sv
// Self-checking bench for mmss_counter: directed table, corner sequences, random run.
module tb_mmss_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0, key = 1'b0, clr = 1'b0;
  logic [6:0] h0, h1, h2, h3, b0, b1, b2, b3;
  logic run_a, wrap_a, run_b, wrap_b;

  always #5 clk = ~clk;

  mmss_counter #(.BLANK_LEADING(1'b0)) dut_a (
    .CLOCK_50(clk), .reset_n(rst_n), .tick(tick), .key_start(key), .clear(clr),
    .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3), .running(run_a), .wrap(wrap_a));

  mmss_counter #(.BLANK_LEADING(1'b1)) dut_b (
    .CLOCK_50(clk), .reset_n(rst_n), .tick(tick), .key_start(key), .clear(clr),
    .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3), .running(run_b), .wrap(wrap_b));

  int errors = 0;
  int checks = 0;

  // Reference model: elapsed seconds as a plain integer
  int m_secs = 0;
  bit m_run = 0, m_key = 0, m_wrap = 0;

  logic [6:0] codes [10];
  initial begin
    codes[0] = 7'h40; codes[1] = 7'h79; codes[2] = 7'h24; codes[3] = 7'h30; codes[4] = 7'h19;
    codes[5] = 7'h12; codes[6] = 7'h02; codes[7] = 7'h78; codes[8] = 7'h00; codes[9] = 7'h10;
  end

  typedef struct {
    bit t;
    bit k;
    bit c;
    int secs;
    bit run;
    bit wr;
  } vec_t;
  vec_t vecs[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk(input string tag, input int secs, input bit run, input bit wr);
    int m1, m0, s1, s0;
    m1 = secs / 600;
    m0 = (secs / 60) % 10;
    s1 = (secs % 60) / 10;
    s0 = secs % 10;
    cmp({tag, " HEX0"}, {25'd0, h0}, {25'd0, codes[s0]});
    cmp({tag, " HEX1"}, {25'd0, h1}, {25'd0, codes[s1]});
    cmp({tag, " HEX2"}, {25'd0, h2}, {25'd0, codes[m0]});
    cmp({tag, " HEX3"}, {25'd0, h3}, {25'd0, codes[m1]});
    cmp({tag, " blank HEX0"}, {25'd0, b0}, {25'd0, codes[s0]});
    cmp({tag, " blank HEX1"}, {25'd0, b1}, {25'd0, codes[s1]});
    cmp({tag, " blank HEX2"}, {25'd0, b2}, {25'd0, codes[m0]});
    cmp({tag, " blank HEX3"}, {25'd0, b3}, (m1 == 0) ? 32'h7F : {25'd0, codes[m1]});
    cmp({tag, " running"}, {31'd0, run_a}, {31'd0, run});
    cmp({tag, " wrap"}, {31'd0, wrap_a}, {31'd0, wr});
    cmp({tag, " blank running"}, {31'd0, run_b}, {31'd0, run});
    cmp({tag, " blank wrap"}, {31'd0, wrap_b}, {31'd0, wr});
  endtask

  task automatic model_edge();
    bit edge_k, cnt;
    edge_k = key && !m_key;
    m_key = key;
    if (clr) begin
      m_secs = 0;
      m_run = 0;
      m_wrap = 0;
    end else begin
      cnt = tick && m_run;
      m_wrap = cnt && (m_secs == 3599);
      if (cnt) m_secs = (m_secs + 1) % 3600;
      if (edge_k) m_run = !m_run;
    end
  endtask

  task automatic model_reset();
    m_secs = 0; m_run = 0; m_key = 0; m_wrap = 0;
  endtask

  task automatic cycle(input bit t, input bit k, input bit c);
    @(negedge clk);
    tick = t; key = k; clr = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input bit t, input bit k, input bit c, input string tag);
    cycle(t, k, c);
    chk(tag, m_secs, m_run, m_wrap);
  endtask

  task automatic add(input bit t, input bit k, input bit c, input int s, input bit r, input bit w);
    vec_t v;
    v.t = t; v.k = k; v.c = c; v.secs = s; v.run = r; v.wr = w;
    vecs.push_back(v);
  endtask

  initial begin
    // Directed table: start, 10 ticks, simultaneous toggle/tick, clear interactions
    add(0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 10; i++) add(1, 0, 0, i, 1, 0);
    add(1, 1, 0, 11, 0, 0);
    add(1, 0, 0, 11, 0, 0);
    add(1, 1, 0, 11, 1, 0);
    add(1, 1, 0, 12, 1, 0);
    add(0, 0, 0, 12, 1, 0);
    add(1, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    foreach (vecs[i]) begin
      cycle(vecs[i].t, vecs[i].k, vecs[i].c);
      chk($sformatf("vec%0d", i), vecs[i].secs, vecs[i].run, vecs[i].wr);
    end

    // Rollover 59:58 -> 59:59 -> 00:00
    for (int i = 0; i < 3598; i++) step(1, 0, 0, "run_up");
    cycle(1, 0, 0); chk("at_5959", 3599, 1, 0);
    cycle(1, 0, 0); chk("rollover", 0, 1, 1);
    cycle(0, 0, 0); chk("after_wrap", 0, 1, 0);

    // Stop with tick at 00:05
    step(0, 0, 1, "clr");
    step(0, 1, 0, "start");
    step(0, 0, 0, "rel");
    for (int i = 0; i < 5; i++) step(1, 0, 0, "to_0005");
    cycle(1, 1, 0); chk("stop_tick", 6, 0, 0);
    step(0, 0, 0, "rel2");
    step(1, 0, 0, "stopped_tick");

    // Clear with tick at 12:34
    step(0, 1, 0, "start2");
    step(0, 0, 0, "rel3");
    for (int i = 0; i < 748; i++) step(1, 0, 0, "to_1234");
    chk("at_1234", 754, 1, 0);
    cycle(1, 0, 1); chk("clear_tick", 0, 0, 0);

    // Asynchronous reset at 03:07
    step(0, 1, 0, "start3");
    step(0, 0, 0, "rel4");
    for (int i = 0; i < 187; i++) step(1, 0, 0, "to_0307");
    chk("at_0307", 187, 1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, "post_reset");

    // Random stimulus against the model
    for (int i = 0; i < 2000; i++) begin
      bit t, k, c;
      t = ($urandom_range(0, 1) == 1);
      k = ($urandom_range(0, 7) == 0) ? !key : key;
      c = ($urandom_range(0, 63) == 0);
      step(t, k, c, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmss_counter.md
# mmss_counter

Minutes:seconds stopwatch core for the four-digit 7-segment display lab. It sits directly downstream of the one-second tick generator and consumes its one-cycle `tick` pulse. It counts elapsed time 00:00–59:59 in BCD under start/stop and clear control, and drives four active-low 7-segment digits (HEX3..HEX0 = M1 M0 S1 S0).

## Interface
- `BLANK_LEADING`, default 0: when 1, HEX3 is blank (all segments off) while the minutes-tens digit is 0.
- `CLOCK_50`  in  1  system clock; all state is updated on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle advance pulse from the one-second tick generator.
- `key_start`  in  1  start/stop control (level input).
  - Each rising edge toggles STOPPED/RUNNING.
  - Input arrives already debounced and synchronised.
- `clear`  in  1  synchronous clear, active-high.
- `HEX0`..`HEX3`  out  7 each  segment patterns, active-low.
  - Bit order: bit0 = a … bit6 = g.
- `running`  out  1  high while in RUNNING.
- `wrap`  out  1  one-cycle pulse on the 59:59 → 00:00 rollover.

## Operation
- States: STOPPED (reset state) and RUNNING.
- Edge detect:
  - `key_q` is a register of `key_start`; reset value 0.
  - `start_edge = key_start & ~key_q`.
  - `start_edge` toggles the state.
- Digits `s0`, `s1`, `m0`, `m1` are 4-bit BCD registers. Ranges:
  - `s0`: 0–9
  - `s1`: 0–5
  - `m0`: 0–9
  - `m1`: 0–5
- Increment on each edge with `tick` = 1 while the current state is RUNNING, ripple style:
  - `s0` 9 → 0 carries into `s1`.
  - `s1` 5 → 0 carries into `m0`.
  - `m0` 9 → 0 carries into `m1`.
  - `m1` 5 → 0 (all digits at 59:59) sets `wrap` for one cycle. The counter stays RUNNING.
- While STOPPED, ticks are ignored.
- Priority per edge, highest first:
  1. `clear`: all digits 0, state forced to STOPPED, `wrap` 0. A simultaneous toggle edge is consumed (`key_q` still updates) and lost.
  2. Toggle plus tick in the same cycle: the tick is qualified by the pre-edge state.
     - STOPPED → RUNNING with tick: the tick is not counted.
     - RUNNING → STOPPED with tick: the tick is counted.
  3. Otherwise, normal increment.
- Digit values above their range cannot arise. If one does, the decoder shows blank.
- Reset values:
  - Digits 0, STOPPED, `key_q` 0.
  - `running` 0, `wrap` 0.
  - HEX0–HEX3 = 0x40 ("0"). With `BLANK_LEADING` = 1, HEX3 = 0x7F.

## Timing
- `running` and `wrap` are registered outputs.
- HEX outputs are a combinational decode of the registered digits, so they change right after the edge that updates the digits.
- Tick-to-display latency: 1 edge. The digit updates on the edge that samples `tick` = 1.
- Toggle latency: `running` changes on the first edge that samples `key_start` high after a low sample. Holding `key_start` high gives exactly one toggle.
- `wrap` is high for exactly the cycle following the rolling edge.
- Reset assertion mid-count:
  - Immediately (asynchronously) zeroes all registers; no clock edge needed.
  - Normal operation resumes on the first edge after deassertion.
- Segment codes (active-low hex):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10
  - blank = 7F

## Structure
- Package `mmss_pkg` contains:
  - `typedef logic [3:0] bcd_t`
  - state enum `{STOPPED, RUNNING}`
  - `typedef logic [6:0] seg_t`
  - constants `SEG_BLANK` (7'h7F) and the ten digit codes
- Sub-module `seg7_decoder`: combinational `bcd_t` → `seg_t` decoder, instantiated four times.

## Test plan
- Reset:
  - Stimulus: assert `reset_n` = 0 for 3 cycles, then release.
  - Response: HEX3..0 = 40 40 40 40, `running` = 0, `wrap` = 0.
- Counting:
  - Stimulus: pulse `key_start` once, then apply 10 ticks.
  - Response: `running` = 1; display 00:10, i.e. HEX1 = 79, HEX0 = 40.
- Rollover:
  - Stimulus: run to 59:58, then apply 2 ticks.
  - Response: display 59:59, then 00:00; `wrap` is high for exactly one cycle; `running` stays 1.
- Stopped and simultaneous events:
  - Ticks while STOPPED leave the display unchanged.
  - Toggle edge plus tick while STOPPED: not counted.
  - Toggle edge plus tick while RUNNING at 00:05: display 00:06, `running` = 0.
- Clear:
  - Stimulus: `clear` pulse at 12:34 while RUNNING, in the same cycle as a tick.
  - Response: display 00:00, `running` = 0.
- Asynchronous reset and blanking:
  - Stimulus: drop `reset_n` between clock edges at 03:07.
  - Response: outputs go to reset values before the next edge.
  - With `BLANK_LEADING` = 1 at 03:07, HEX3 = 7F.
